bcd_calc_scan: RTL and testbench
================================

// Module: bcd_calc_scan
// PURPOSE
// - DIGITS-wide packed-BCD add/subtract unit, processing one digit per clock, with a start/done handshake.
// - Has a built-in multiplexed 7-segment scanner that shows num1, num2 and the result.
// - Replaces the fixed two-digit combinational calculator on the board top level.
// - Operands and result are registered, so the display and flags stay coherent with the last completed operation.
// PARAMETERS
// - DIGITS    2   BCD digits per operand/result (>=1); buses are 4*DIGITS bits
// - SCAN_DIV  15  display advances one row every 2**SCAN_DIV clk cycles (>=1)
// PORTS
// - clk      in   1          system clock; only clock, all flops on rising edge
// - rst      in   1          reset, asynchronous, active-high
// - start    in   1          request operation; sampled only in IDLE
// - sel      in   1          1 = add, 0 = subtract; latched with start
// - num1     in   4*DIGITS   operand A, packed BCD, MS digit in top nibble
// - num2     in   4*DIGITS   operand B, packed BCD
// - busy     out  1          operation in progress
// - done     out  1          one-cycle pulse: out/flow/err valid and updated
// - out      out  4*DIGITS   registered result, packed BCD
// - flow     out  1          add: carry out of MS digit; sub: borrow (A<B)
// - err      out  1          an operand digit was >9 in the last operation
// - ssg      out  8          {A,B,C,D,E,F,G,DOT} from the ssgfont instance
// - ssg_row  out  3*DIGITS+2 one-hot row select, 0 on blank positions
// BEHAVIOUR
// - Reset: state IDLE; busy/done/flow/err = 0; out, latched operands, scan row and prescaler = 0.
// - FSM IDLE -> CALC -> DONE -> IDLE.
//   - IDLE & start: latch num1, num2, sel; digit index i=0; carry/borrow = 0 (sub uses borrow).
//   - CALC: one digit per cycle, LS first, for DIGITS cycles.
//     - add: s=a+b+c; if s>9 then s-=10, c=1.
//     - sub: d=a-b-bw; if d<0 then d+=10, bw=1.
//     - Write result digit i.
//   - DONE: drive out, flow and err from the working registers; done=1 for exactly this cycle.
// - Timing: busy rises on the edge that samples start. done is high during the cycle after the DIGITS-th CALC edge.
//   - Latency from start to done = DIGITS+1 clocks.
//   - busy falls on the edge that leaves DONE.
// - start while busy (CALC/DONE) is ignored and is not queued. start in the same cycle done is high is ignored.
// - Subtract with A<B: out = ten's complement (A-B) mod 10**DIGITS, flow = 1. Example: 23-50 -> 73, flow 1.
// - Add overflow wraps: 99+01 -> 00, flow 1.
// - Any latched operand digit >9: err = 1, out = 0, flow = 0 at DONE.
// - out holds its value between operations.
// - rst mid-operation: immediate return to IDLE with reset values; no done pulse.
// - Scanner: free-running prescaler; the row index advances mod 3*DIGITS+2 when the prescaler wraps. No derived clocks.
//   - Position map (0 = leftmost): num1 MS..LS, blank, num2 MS..LS, blank, result MS..LS.
//   - Blank positions drive ssg_row = 0.
//   - Operand fields display the latched operands, not the live inputs.
// CONFIGURATION
// - LEADING_ZERO_BLANK_EN defined: in each field, leading zero digits except the LS digit drive ssg_row = 0.
//   - Example: 05 shows only the 5.
// - LEADING_ZERO_BLANK_EN undefined: all digit rows are always driven.
// STRUCTURE
// - Package bcd_calc_pkg:
//   - FSM state typedef (IDLE/CALC/DONE)
//   - BCD_MAX = 4'd9, BCD_BASE = 5'd10
//   - Function giving the row count (3*DIGITS+2) from DIGITS.
// - Sub-module bcd_digit_alu: combinational one-digit add/sub with carry/borrow in and out, plus a digit_invalid flag.
// - Reuses the existing ssgfont for segment encoding, with dot tied to 0.
// TESTING (DIGITS=2, SCAN_DIV=2 unless noted)
// - Add 45+38, sel=1, start for 1 cycle -> done 3 clocks later; out=8'h83, flow=0, err=0; busy high for exactly 3 cycles.
// - Add 99+01 -> out=8'h00, flow=1. Sub 50-23 -> out=8'h27, flow=0. Sub 23-50 -> out=8'h73, flow=1.
// - num1=8'h1A, add -> err=1, out=8'h00, flow=0. A following valid op clears err.
// - start held high for 10 cycles -> back-to-back ops spaced 4 cycles apart.
//   - rst asserted in CALC -> busy=0, out=0 asynchronously, no done pulse.
// - Scan: ssg_row goes through 01,02,00,08,10,00,40,80 (8-bit, DIGITS=2), stepping every 4 clocks and wrapping.
//   - With LEADING_ZERO_BLANK_EN and result 05: row 0x40 reads 00.
//   - DIGITS=4 build: 1234+8766 -> out=16'h0000, flow=1, done after 5 clocks.

Source files
------------

// File: rtl/bcd_calc_pkg.sv
// Shared types and constants for the serial BCD calculator and its display scanner.
package bcd_calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [4:0] BCD_BASE = 5'd10;

  // Display positions: num1 digits, blank, num2 digits, blank, result digits.
  function automatic int row_count(input int digits);
    return 3 * digits + 2;
  endfunction

endpackage

// File: rtl/bcd_digit_alu.sv
// One BCD digit add/subtract with carry/borrow in and out; combinational.
module bcd_digit_alu
  import bcd_calc_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  input  logic       i_add,
  output logic [3:0] o_y,
  output logic       o_cout,
  output logic       o_digit_invalid
);

  logic [4:0] w_sum;
  logic [4:0] w_diff;

  always_comb begin
    w_sum  = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_cin};
    w_diff = {1'b0, i_a} - {1'b0, i_b} - {4'd0, i_cin};
    o_y    = 4'd0;
    o_cout = 1'b0;
    if (i_add) begin
      if (w_sum > {1'b0, BCD_MAX}) begin
        o_y    = 4'(w_sum - BCD_BASE);
        o_cout = 1'b1;
      end else begin
        o_y = w_sum[3:0];
      end
    end else begin
      // Bit 4 set means the 5-bit difference went negative.
      if (w_diff[4]) begin
        o_y    = 4'(w_diff + BCD_BASE);
        o_cout = 1'b1;
      end else begin
        o_y = w_diff[3:0];
      end
    end
    o_digit_invalid = (i_a > BCD_MAX) || (i_b > BCD_MAX);
  end

endmodule

// File: rtl/ssgfont.sv
// Hex digit to 7-segment font, active-high segments {A,B,C,D,E,F,G,DOT}.
module ssgfont (
  input  logic [3:0] i_dig,
  input  logic       i_dot,
  output logic [7:0] o_ssg
);

  logic [6:0] w_seg;

  always_comb begin
    w_seg = 7'b0000000;
    case (i_dig)
      4'h0: w_seg = 7'b1111110;
      4'h1: w_seg = 7'b0110000;
      4'h2: w_seg = 7'b1101101;
      4'h3: w_seg = 7'b1111001;
      4'h4: w_seg = 7'b0110011;
      4'h5: w_seg = 7'b1011011;
      4'h6: w_seg = 7'b1011111;
      4'h7: w_seg = 7'b1110000;
      4'h8: w_seg = 7'b1111111;
      4'h9: w_seg = 7'b1111011;
      4'hA: w_seg = 7'b1110111;
      4'hB: w_seg = 7'b0011111;
      4'hC: w_seg = 7'b1001110;
      4'hD: w_seg = 7'b0111101;
      4'hE: w_seg = 7'b1001111;
      4'hF: w_seg = 7'b1000111;
      default: w_seg = 7'b0000000;
    endcase
    o_ssg = {w_seg, i_dot};
  end

endmodule

// File: rtl/bcd_calc_scan.sv
// Serial packed-BCD add/subtract (one digit per clock, start/done) with a 7-segment scanner.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits in each displayed field.
module bcd_calc_scan
  import bcd_calc_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sel,
  input  logic [4*DIGITS-1:0]   num1,
  input  logic [4*DIGITS-1:0]   num2,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   out,
  output logic                  flow,
  output logic                  err,
  output logic [7:0]            ssg,
  output logic [3*DIGITS+1:0]   ssg_row
);

  localparam int W    = 4 * DIGITS;
  localparam int ROWS = row_count(DIGITS);
  localparam int RW   = $clog2(ROWS);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          r_state, w_next;
  logic [W-1:0]    r_a, r_b, r_res, w_res_next;
  logic            r_add, r_c, r_inv;
  logic [IW-1:0]   r_idx;
  logic [SCAN_DIV-1:0] r_pre;
  logic [RW-1:0]   r_row, w_k;
  logic [3:0]      w_y, w_dig;
  logic            w_cout, w_dinv, w_last, w_inv_all, w_on;
  logic [W-1:0]    w_field;

  bcd_digit_alu u_alu (
    .i_a             (r_a[4*r_idx +: 4]),
    .i_b             (r_b[4*r_idx +: 4]),
    .i_cin           (r_c),
    .i_add           (r_add),
    .o_y             (w_y),
    .o_cout          (w_cout),
    .o_digit_invalid (w_dinv)
  );

  assign w_last    = (r_idx == IW'(DIGITS - 1));
  assign w_inv_all = r_inv | w_dinv;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);

  always_comb begin
    w_res_next = r_res;
    w_res_next[4*r_idx +: 4] = w_y;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_add   <= 1'b0;
      r_c     <= 1'b0;
      r_inv   <= 1'b0;
      r_idx   <= '0;
      out     <= '0;
      flow    <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= num1;
            r_b   <= num2;
            r_add <= sel;
            r_idx <= '0;
            r_c   <= 1'b0;
            r_inv <= 1'b0;
          end
        end
        CALC: begin
          r_res <= w_res_next;
          r_c   <= w_cout;
          r_inv <= w_inv_all;
          r_idx <= r_idx + 1'b1;
          // Outputs load on the final digit so they are valid while done is high.
          if (w_last) begin
            err  <= w_inv_all;
            out  <= w_inv_all ? '0 : w_res_next;
            flow <= w_inv_all ? 1'b0 : w_cout;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_row <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
      if (&r_pre) begin
        r_row <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
      end
    end
  end

  always_comb begin
    w_field = '0;
    w_k     = '0;
    w_on    = 1'b0;
    if (r_row < RW'(DIGITS)) begin
      w_field = r_a;
      w_k     = r_row;
      w_on    = 1'b1;
    end else if ((r_row > RW'(DIGITS)) && (r_row <= RW'(2 * DIGITS))) begin
      w_field = r_b;
      w_k     = r_row - RW'(DIGITS + 1);
      w_on    = 1'b1;
    end else if (r_row >= RW'(2 * DIGITS + 2)) begin
      w_field = out;
      w_k     = r_row - RW'(2 * DIGITS + 2);
      w_on    = 1'b1;
    end
    w_dig = 4'(w_field >> (4 * (DIGITS - 1 - int'(w_k))));
`ifdef LEADING_ZERO_BLANK_EN
    if (((w_field >> (4 * (DIGITS - 1 - int'(w_k)))) == '0) && (int'(w_k) != DIGITS - 1))
      w_on = 1'b0;
`endif
    ssg_row = '0;
    if (w_on) ssg_row[r_row] = 1'b1;
  end

  ssgfont u_font (
    .i_dig (w_dig),
    .i_dot (1'b0),
    .o_ssg (ssg)
  );

endmodule

// File: tb/tb_bcd_calc_scan.sv
// Randomized self-checking bench for bcd_calc_scan against an integer-arithmetic model.
module tb_bcd_calc_scan;

  localparam int DIGITS   = 2;
  localparam int SCAN_DIV = 2;
  localparam int W        = 4 * DIGITS;
  localparam int ROWS     = 3 * DIGITS + 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            sel = 1'b0;
  logic [W-1:0]    num1 = '0;
  logic [W-1:0]    num2 = '0;
  logic            busy, done, flow, err;
  logic [W-1:0]    out;
  logic [7:0]      ssg;
  logic [ROWS-1:0] ssg_row;

  int n_vec = 0;
  int n_err = 0;
  int ecnt  = 0;
  logic [W-1:0] lat_a = '0, lat_b = '0, exp_out_reg = '0;

  bcd_calc_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .num1(num1), .num2(num2),
    .busy(busy), .done(done), .out(out), .flow(flow), .err(err),
    .ssg(ssg), .ssg_row(ssg_row)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit b = 0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) b = 1;
    return b;
  endfunction

  function automatic logic [7:0] font(input logic [3:0] d);
    logic [7:0] t [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                           8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    return t[d];
  endfunction

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] eo, output logic ef, output logic ee);
    int m = 1;
    int av, bv;
    for (int i = 0; i < DIGITS; i++) m = m * 10;
    av = bcd2int(a);
    bv = bcd2int(b);
    if (has_bad(a) || has_bad(b)) begin
      ee = 1'b1; eo = '0; ef = 1'b0;
    end else if (s) begin
      ee = 1'b0; eo = int2bcd((av + bv) % m); ef = (av + bv >= m);
    end else begin
      ee = 1'b0; eo = int2bcd((av - bv + m) % m); ef = (av < bv);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output int lat, output int bcnt, output logic [W-1:0] o,
                        output logic f, output logic e, output logic done_after);
    @(negedge clk);
    num1 = a; num2 = b; sel = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
    o = out; f = flow; e = err;
    @(posedge clk); #1;
    if (busy) bcnt++;
    done_after = done;
    lat_a = a; lat_b = b;
  endtask

  task automatic test_reset;
    logic [ROWS-1:0] er;
`ifdef LEADING_ZERO_BLANK_EN
    er = '0;
`else
    er = ROWS'(1);
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if ({busy, done, flow, err} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", {busy, done, flow, err}); end
    n_vec++; if (out !== '0) begin n_err++; $display("FAIL reset_out got %h want 0", out); end
    n_vec++; if (ssg_row !== er) begin n_err++; $display("FAIL reset_row got %h want %h", ssg_row, er); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [6] = '{8'h45, 8'h99, 8'h50, 8'h23, 8'h1A, 8'h12};
    logic [W-1:0] tb [6] = '{8'h38, 8'h01, 8'h23, 8'h50, 8'h05, 8'h30};
    logic         ts [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] to [6] = '{8'h83, 8'h00, 8'h27, 8'h73, 8'h00, 8'h42};
    logic         tf [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic         te [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat, bcnt;
    logic [W-1:0] o;
    logic f, e, da;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], ts[i], lat, bcnt, o, f, e, da);
      n_vec++; if (o !== to[i]) begin n_err++; $display("FAIL dir_out[%0d] got %h want %h", i, o, to[i]); end
      n_vec++; if ({f, e} !== {tf[i], te[i]}) begin n_err++; $display("FAIL dir_flow_err[%0d] got %b want %b", i, {f, e}, {tf[i], te[i]}); end
      n_vec++; if (lat !== DIGITS + 1) begin n_err++; $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, DIGITS + 1); end
      n_vec++; if (bcnt !== DIGITS + 1) begin n_err++; $display("FAIL dir_busy_cycles[%0d] got %0d want %0d", i, bcnt, DIGITS + 1); end
      n_vec++; if (da !== 1'b0) begin n_err++; $display("FAIL dir_done_pulse[%0d] done still high after one cycle", i); end
      n_vec++; if (out !== to[i]) begin n_err++; $display("FAIL dir_out_hold[%0d] got %h want %h", i, out, to[i]); end
    end
    exp_out_reg = to[5];
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, eo, o;
    logic s, ef, ee, f, e, da;
    int lat, bcnt;
    for (int n = 0; n < 40; n++) begin
      a = int2bcd($urandom_range(0, 99));
      b = int2bcd($urandom_range(0, 99));
      if ($urandom_range(0, 7) == 0) a[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) b[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      s = 1'($urandom_range(0, 1));
      model(a, b, s, eo, ef, ee);
      run_op(a, b, s, lat, bcnt, o, f, e, da);
      n_vec++;
      if ({o, f, e} !== {eo, ef, ee} || lat !== DIGITS + 1) begin
        n_err++;
        $display("FAIL rand[%0d] %h %s %h got out=%h flow=%b err=%b lat=%0d want out=%h flow=%b err=%b lat=%0d",
                 n, a, s ? "+" : "-", b, o, f, e, lat, eo, ef, ee, DIGITS + 1);
      end
      exp_out_reg = eo;
    end
  endtask

  task automatic test_back_to_back;
    logic exp_d;
    @(negedge clk);
    num1 = 8'h12; num2 = 8'h34; sel = 1'b1; start = 1'b1;
    for (int e = 0; e < 14; e++) begin
      @(posedge clk); #1;
      if (e == 9) start = 1'b0;
      exp_d = (e % 4 == 2) && (e <= 10);
      n_vec++; if (done !== exp_d) begin n_err++; $display("FAIL b2b_done[%0d] got %b want %b", e, done, exp_d); end
      if (exp_d) begin
        n_vec++; if (out !== 8'h46) begin n_err++; $display("FAIL b2b_out[%0d] got %h want 46", e, out); end
      end
    end
    lat_a = 8'h12; lat_b = 8'h34; exp_out_reg = 8'h46;
  endtask

  task automatic test_rst_mid;
    int lat, bcnt;
    logic [W-1:0] o;
    logic f, e, da, seen;
    run_op(8'h45, 8'h38, 1'b1, lat, bcnt, o, f, e, da);
    @(negedge clk);
    num1 = 8'h77; num2 = 8'h11; sel = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_vec++; if ({busy, done, flow, err} !== 4'b0000) begin n_err++; $display("FAIL rstmid_flags got %b want 0000", {busy, done, flow, err}); end
    n_vec++; if (out !== '0) begin n_err++; $display("FAIL rstmid_out got %h want 0", out); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_done got activity=%b want 0", seen); end
    lat_a = '0; lat_b = '0; exp_out_reg = '0;
  endtask

  task automatic test_scan(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int lat, bcnt, p, k;
    logic [W-1:0] o, eo, fld;
    logic f, e, da, ef, ee, on, lz;
    logic [ROWS-1:0] er;
    logic [3:0] dg;
    model(a, b, s, eo, ef, ee);
    run_op(a, b, s, lat, bcnt, o, f, e, da);
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      p = (ecnt / (1 << SCAN_DIV)) % ROWS;
      on = 1'b1; fld = '0; k = 0;
      if (p < DIGITS) begin fld = a; k = p; end
      else if (p == DIGITS || p == 2 * DIGITS + 1) on = 1'b0;
      else if (p <= 2 * DIGITS) begin fld = b; k = p - DIGITS - 1; end
      else begin fld = eo; k = p - 2 * DIGITS - 2; end
      dg = fld[4*(DIGITS-1-k) +: 4];
      lz = (k < DIGITS - 1);
      for (int j = 0; j <= k; j++) if (fld[4*(DIGITS-1-j) +: 4] != 4'd0) lz = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (lz) on = 1'b0;
`endif
      er = on ? (ROWS'(1) << p) : '0;
      n_vec++; if (ssg_row !== er) begin n_err++; $display("FAIL scan_row[%0d] pos %0d got %h want %h", n, p, ssg_row, er); end
      if (on) begin
        n_vec++; if (ssg !== font(dg)) begin n_err++; $display("FAIL scan_seg[%0d] pos %0d got %h want %h", n, p, ssg, font(dg)); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_rst_mid;
    test_scan(8'h05, 8'h00, 1'b1);
    test_scan(8'h47, 8'h19, 1'b0);
    test_scan(8'h03, 8'h08, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
